// File: rtl/iob_ram_2p_sync.sv
// Single-clock two-port RAM: one write-only port, one read-only port.
// Read data is registered, read-first on same-address collisions.
module iob_ram_2p_sync #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              w_en_i,
  input  logic [ADDR_W-1:0] w_addr_i,
  input  logic [DATA_W-1:0] w_data_i,
  input  logic              r_en_i,
  input  logic [ADDR_W-1:0] r_addr_i,
  output logic [DATA_W-1:0] r_data_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] r_data_q = '0;
  logic [DATA_W-1:0] r_data_d;
  logic              w_fire;
  logic              r_fire;

  // Reset takes priority over both ports in its cycle.
  always_comb begin
    w_fire = w_en_i & ~rst_i;
    r_fire = r_en_i & ~rst_i;
  end

  always_ff @(posedge clk_i) begin
    if (w_fire) begin
      mem_q[w_addr_i] <= w_data_i;
    end
  end

  // The array is read before this edge's write lands, giving read-first.
  always_comb begin
    r_data_d = r_data_q;
    if (rst_i) begin
      r_data_d = '0;
    end else if (r_fire) begin
      r_data_d = mem_q[r_addr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    r_data_q <= r_data_d;
  end

  assign r_data_o = r_data_q;

endmodule

// File: tb/tb_iob_ram_2p_sync.sv
// Directed self-checking bench for iob_ram_2p_sync (DATA_W=8, ADDR_W=4).
module tb_iob_ram_2p_sync;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int SEQ_INI = 32;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              w_en_i = 1'b0;
  logic [ADDR_W-1:0] w_addr_i = '0;
  logic [DATA_W-1:0] w_data_i = '0;
  logic              r_en_i = 1'b0;
  logic [ADDR_W-1:0] r_addr_i = '0;
  logic [DATA_W-1:0] r_data_o;

  int n_vec = 0;
  int n_err = 0;

  iob_ram_2p_sync #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .w_en_i  (w_en_i),
    .w_addr_i(w_addr_i),
    .w_data_i(w_data_i),
    .r_en_i  (r_en_i),
    .r_addr_i(r_addr_i),
    .r_data_o(r_data_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] exp);
    n_vec++;
    $display("vec %0d %s: r_data_o=%02h exp=%02h", n_vec, tag, r_data_o, exp);
    assert (r_data_o === exp) else begin
      n_err++;
      $error("FAIL %s: r_data_o=%02h expected %02h", tag, r_data_o, exp);
    end
  endtask

  initial begin
    #1;
    // Reset
    rst_i = 1'b1;
    tick();
    check("reset", 8'h00);
    rst_i = 1'b0;

    // 1. Fill: writes must not disturb the read register
    w_en_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w_addr_i = ADDR_W'(i);
      w_data_i = DATA_W'(SEQ_INI + i);
      tick();
      check($sformatf("fill_%0d", i), 8'h00);
    end
    w_en_i = 1'b0;

    // 2. Disabled read sweep
    r_en_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      r_addr_i = ADDR_W'(i);
      tick();
      check($sformatf("rd_off_%0d", i), 8'h00);
    end

    // 3. Enabled read sweep
    r_en_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      r_addr_i = ADDR_W'(i);
      tick();
      check($sformatf("rd_%0d", i), DATA_W'(SEQ_INI + i));
    end

    // 4. Hold with read disabled
    r_addr_i = 4'd5;
    tick();
    check("hold_load", 8'd37);
    r_en_i   = 1'b0;
    r_addr_i = 4'd9;
    tick();
    check("hold_1", 8'd37);
    tick();
    check("hold_2", 8'd37);

    // 5. Collision is read-first
    w_en_i   = 1'b1;
    w_addr_i = 4'd3;
    w_data_i = 8'hAA;
    r_en_i   = 1'b1;
    r_addr_i = 4'd3;
    tick();
    check("coll_old", 8'd35);
    w_en_i = 1'b0;
    tick();
    check("coll_new", 8'hAA);

    // Independent ports: different addresses in one cycle
    w_en_i   = 1'b1;
    w_addr_i = 4'd7;
    w_data_i = 8'h5C;
    r_addr_i = 4'd6;
    tick();
    check("indep_rd6", 8'd38);
    w_en_i   = 1'b0;
    r_addr_i = 4'd7;
    tick();
    check("indep_rd7", 8'h5C);

    // 6. Reset blocks same-cycle write/read and keeps contents
    r_addr_i = 4'd8;
    tick();
    check("pre_rst", 8'd40);
    rst_i    = 1'b1;
    w_en_i   = 1'b1;
    w_addr_i = 4'd0;
    w_data_i = 8'hFF;
    r_en_i   = 1'b1;
    r_addr_i = 4'd0;
    tick();
    check("rst_zero", 8'h00);
    rst_i  = 1'b0;
    w_en_i = 1'b0;
    tick();
    check("post_rst_rd0", 8'd32);
    r_addr_i = 4'd15;
    tick();
    check("post_rst_rd15", 8'd47);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
